// File: rtl/sfi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sfi_pkg
// Brief    : Shared types, default sandbox constants and the tag check helper
//            used by the SFI request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sfi_pkg;

    // Sequencer states of the request arbiter
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } sfi_state_e;

    // Default sandbox tag field placement and value
    localparam int unsigned c_TAG_LO      = 24;
    localparam int unsigned c_TAG_W       = 8;
    localparam logic [7:0]  c_SANDBOX_TAG = 8'hA2;

    // Widest address the tag helper evaluates
    localparam int unsigned c_MAX_AW      = 64;

    // True when the tag field [tag_lo +: tag_w] of addr equals tag
    function automatic logic tag_ok(
        input logic [c_MAX_AW-1:0] addr,
        input int unsigned         tag_lo,
        input int unsigned         tag_w,
        input logic [c_MAX_AW-1:0] tag
    );
        logic [c_MAX_AW-1:0] w_mask;
        if (tag_w >= c_MAX_AW) begin
            w_mask = '1;
        end else begin
            w_mask = (64'd1 << tag_w) - 64'd1;
        end
        return ((addr >> tag_lo) & w_mask) == tag;
    endfunction

endpackage : sfi_pkg
`default_nettype wire

// File: rtl/sfi_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : sfi_rr_arb
// Brief    : NREQ-wide round-robin priority picker. Returns the first valid
//            requester at or above rr, wrapping from NREQ-1 back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sfi_rr_arb #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         req_valid,
    input  logic [$clog2(NREQ)-1:0] rr,
    output logic                    gnt_vld,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int unsigned c_IW = $clog2(NREQ);

    int w_pos;

    // Walk priority offsets from lowest priority to highest so the nearest
    // valid requester to rr is the last (winning) assignment
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        w_pos   = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            w_pos = int'(rr) + k;
            if (w_pos >= int'(NREQ)) begin
                w_pos = w_pos - int'(NREQ);
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if ((i == w_pos) && req_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = c_IW'(i);
                end
            end
        end
    end

endmodule : sfi_rr_arb
`default_nettype wire

// File: rtl/sfi_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : sfi_req_arb
// Brief    : Round-robin arbiter/sequencer sharing one sandbox address check
//            between NREQ requesters. Legal addresses go to the memory port,
//            illegal ones get a fault response and bump a saturating counter.
//            Optional macro SFI_FAULT_LOG_EN keeps the last faulting
//            address/requester in fault_addr/fault_id (tied to 0 otherwise).
//            Addresses wider than 64 bits are not supported by the tag check.
// Revision : 1.0 - initial release
// ============================================================================
module sfi_req_arb
    import sfi_pkg::*;
#(
    parameter int unsigned      NREQ        = 2,
    parameter int unsigned      AW          = 64,
    parameter int unsigned      TAG_LO      = c_TAG_LO,
    parameter int unsigned      TAG_W       = c_TAG_W,
    parameter logic [TAG_W-1:0] SANDBOX_TAG = TAG_W'(c_SANDBOX_TAG),
    parameter int unsigned      CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*AW-1:0]      req_addr,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic                    rsp_fault,
    output logic                    mem_valid,
    output logic [AW-1:0]           mem_addr,
    input  logic                    mem_ready,
    output logic [$clog2(NREQ)-1:0] mem_id,
    output logic [CNT_W-1:0]        fault_cnt,
    output logic [AW-1:0]           fault_addr,
    output logic [$clog2(NREQ)-1:0] fault_id
);

    localparam int unsigned c_IW = $clog2(NREQ);

    sfi_state_e        r_state;
    logic [c_IW-1:0]   r_rr;
    logic [c_IW-1:0]   r_id_q;
    logic [AW-1:0]     r_addr_q;
    logic              r_mem_valid;
    logic [AW-1:0]     r_mem_addr;
    logic [c_IW-1:0]   r_mem_id;
    logic [CNT_W-1:0]  r_fault_cnt;

    logic              w_gnt_vld;
    logic [c_IW-1:0]   w_gnt_idx;
    logic [AW-1:0]     w_gnt_addr;
    logic [63:0]       w_addr64;
    logic              w_legal;

    sfi_rr_arb #(
        .NREQ (NREQ)
    ) u_rr_arb (
        .req_valid (req_valid),
        .rr        (r_rr),
        .gnt_vld   (w_gnt_vld),
        .gnt_idx   (w_gnt_idx)
    );

    // Widen the held address to the helper's fixed 64-bit argument
    if (AW < 64) begin : g_addr_pad
        assign w_addr64 = {{(64 - AW){1'b0}}, r_addr_q};
    end else begin : g_addr_full
        assign w_addr64 = r_addr_q[63:0];
    end

    assign w_legal = tag_ok(w_addr64, TAG_LO, TAG_W, 64'(SANDBOX_TAG));

    // Select the granted requester's address slice
    always_comb begin
        w_gnt_addr = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_gnt_idx == c_IW'(i)) begin
                w_gnt_addr = req_addr[i*AW +: AW];
            end
        end
    end

    // Accept strobe in IDLE and completion strobes in ISSUE/FAULT; both are
    // masked while rst is high so nothing is reported for abandoned work
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_fault = !rst && (r_state == FAULT);
        for (int i = 0; i < int'(NREQ); i++) begin
            req_ready[i] = !rst && (r_state == IDLE) && w_gnt_vld &&
                           (w_gnt_idx == c_IW'(i));
            rsp_valid[i] = !rst && (r_id_q == c_IW'(i)) &&
                           (((r_state == ISSUE) && mem_ready) || (r_state == FAULT));
        end
    end

    // Sequencer: grant, check tag, then issue to memory or fault
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr        <= '0;
            r_id_q      <= '0;
            r_addr_q    <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_id    <= '0;
            r_fault_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_addr_q <= w_gnt_addr;
                        r_id_q   <= w_gnt_idx;
                        r_rr     <= (w_gnt_idx == c_IW'(NREQ - 1)) ? '0
                                                                  : w_gnt_idx + c_IW'(1);
                        r_state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_legal) begin
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= r_addr_q;
                        r_mem_id    <= r_id_q;
                        r_state     <= ISSUE;
                    end else begin
                        r_state     <= FAULT;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                FAULT: begin
                    if (r_fault_cnt != {CNT_W{1'b1}}) begin
                        r_fault_cnt <= r_fault_cnt + CNT_W'(1);
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_id    = r_mem_id;
    assign fault_cnt = r_fault_cnt;

`ifdef SFI_FAULT_LOG_EN
    logic [AW-1:0]   r_fault_addr;
    logic [c_IW-1:0] r_fault_id;

    // Remember the most recent rejected request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_addr <= '0;
            r_fault_id   <= '0;
        end else if (r_state == FAULT) begin
            r_fault_addr <= r_addr_q;
            r_fault_id   <= r_id_q;
        end
    end

    assign fault_addr = r_fault_addr;
    assign fault_id   = r_fault_id;
`else
    assign fault_addr = '0;
    assign fault_id   = '0;
`endif

endmodule : sfi_req_arb
`default_nettype wire

// File: tb/tb_sfi_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfi_req_arb
// Brief    : Self-checking bench for sfi_req_arb. A second instance with a
//            2-bit fault counter shares all inputs to exercise saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfi_req_arb;

    localparam int NREQ = 2;
    localparam int AW   = 64;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic              mem_ready;

    logic [NREQ-1:0]   req_ready,  req_ready_s;
    logic [NREQ-1:0]   rsp_valid,  rsp_valid_s;
    logic              rsp_fault,  rsp_fault_s;
    logic              mem_valid,  mem_valid_s;
    logic [AW-1:0]     mem_addr,   mem_addr_s;
    logic [0:0]        mem_id,     mem_id_s;
    logic [15:0]       fault_cnt;
    logic [1:0]        fault_cnt_s;
    logic [AW-1:0]     fault_addr, fault_addr_s;
    logic [0:0]        fault_id,   fault_id_s;

    sfi_req_arb #(.NREQ(NREQ), .AW(AW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_fault(rsp_fault),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_id(mem_id), .fault_cnt(fault_cnt), .fault_addr(fault_addr),
        .fault_id(fault_id)
    );

    sfi_req_arb #(.NREQ(NREQ), .AW(AW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready_s), .rsp_valid(rsp_valid_s), .rsp_fault(rsp_fault_s),
        .mem_valid(mem_valid_s), .mem_addr(mem_addr_s), .mem_ready(mem_ready),
        .mem_id(mem_id_s), .fault_cnt(fault_cnt_s), .fault_addr(fault_addr_s),
        .fault_id(fault_id_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: transaction-level view of the arbiter
    int          rr_model = 0;
    int          nfault   = 0;
    logic [63:0] exp_faddr = '0;
    logic [63:0] exp_fid   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(rr_model + k) % NREQ]) return (rr_model + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit addr_legal(input logic [63:0] a);
        return ((a >> 24) & 64'hFF) == 64'hA2;
    endfunction

    function automatic logic [63:0] onehot(input int g);
        return 64'd1 << g;
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_cnt"}, fault_cnt, (nfault > 65535) ? 65535 : nfault);
        chk({tag, "_cnt_sat"}, fault_cnt_s, (nfault > 3) ? 3 : nfault);
        chk({tag, "_faddr"}, fault_addr, exp_faddr);
        chk({tag, "_fid"}, fault_id, exp_fid);
    endtask

    // One complete transaction; called and returns on a falling edge
    task automatic run_txn(input logic [NREQ-1:0] vmask, input logic [63:0] a0,
                           input logic [63:0] a1, input int stall, output int g_obs);
        int          g;
        logic [63:0] a;
        req_valid = vmask;
        req_addr  = {a1, a0};
        mem_ready = 1'b0;
        g = model_grant(vmask);
        #1;
        g_obs = req_ready[1] ? 1 : (req_ready[0] ? 0 : -1);
        chk("grant", req_ready, onehot(g));
        chk("idle_rsp", rsp_valid, 0);
        @(posedge clk);
        a = (g == 1) ? a1 : a0;
        rr_model = (g + 1) % NREQ;
        @(negedge clk);
        chk("check_ready", req_ready, 0);
        chk("check_memv", mem_valid, 0);
        chk("check_rsp", rsp_valid, 0);
        @(negedge clk);
        if (addr_legal(a)) begin
            chk("issue_memv", mem_valid, 1);
            chk("issue_addr", mem_addr, a);
            chk("issue_id", mem_id, g);
            chk("issue_rsp_wait", rsp_valid, 0);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("stall_memv", mem_valid, 1);
                chk("stall_addr", mem_addr, a);
                chk("stall_ready", req_ready, 0);
                chk("stall_rsp", rsp_valid, 0);
            end
            mem_ready = 1'b1;
            #1;
            chk("issue_rsp", rsp_valid, onehot(g));
            chk("issue_fault", rsp_fault, 0);
            chk("issue_memv_hs", mem_valid, 1);
        end else begin
            chk("fault_memv", mem_valid, 0);
            chk("fault_rsp", rsp_valid, onehot(g));
            chk("fault_flag", rsp_fault, 1);
            nfault++;
`ifdef SFI_FAULT_LOG_EN
            exp_faddr = a;
            exp_fid   = g;
`endif
        end
        @(negedge clk);
        mem_ready = 1'b0;
        req_valid = '0;
        chk("done_memv", mem_valid, 0);
        chk("done_rsp", rsp_valid, 0);
        chk("done_fault", rsp_fault, 0);
        chk_counters("done");
    endtask

    int          g_obs;
    logic [63:0] ra0, ra1;
    int          exp_fair[4] = '{0, 1, 0, 1};
    int          exp_sat[5]  = '{1, 2, 3, 3, 3};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_fault", rsp_fault, 0);
        chk("rst_memv", mem_valid, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_mid", mem_id, 0);
        chk_counters("rst");
        rst = 1'b0;

        // Legal single request from requester 0
        run_txn(2'b01, 64'h00000000_A2199872, 64'h0, 0, g_obs);
        chk("legal_gnt", g_obs, 0);

        // Illegal request from requester 1
        run_txn(2'b10, 64'h0, 64'h00000000_00FFEEDD, 0, g_obs);
        chk("illegal_gnt", g_obs, 1);

        // Fairness: both requesters continuously valid
        for (int t = 0; t < 4; t++) begin
            run_txn(2'b11, 64'h00000000_A2000010 + t, 64'h00000000_A2000020 + t, 0, g_obs);
            chk("fair_seq", g_obs, exp_fair[t]);
        end

        // Backpressure: 5 stalled cycles before mem_ready
        run_txn(2'b01, 64'h12345678_A2ABCDEF, 64'h0, 5, g_obs);

        // Reset while a request sits in ISSUE (requester 0 granted, rr moves on)
        req_valid = 2'b01;
        req_addr  = {64'h0, 64'h00000000_A2000001};
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("pre_rst_memv", mem_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rr_model  = 0;
        nfault    = 0;
        exp_faddr = '0;
        exp_fid   = '0;
        chk("midrst_memv", mem_valid, 0);
        chk("midrst_rsp", rsp_valid, 0);
        chk_counters("midrst");
        @(negedge clk);
        rst = 1'b0;
        run_txn(2'b11, 64'h00000000_A2000100, 64'h00000000_A2000200, 0, g_obs);
        chk("post_rst_gnt", g_obs, 0);

        // Saturation on the 2-bit counter instance
        for (int t = 0; t < 5; t++) begin
            run_txn(2'b01 << (t % 2), 64'h00000000_11000000 + t, 64'h00000000_22000000 + t, 0, g_obs);
            chk("sat_seq", fault_cnt_s, exp_sat[t]);
        end

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            ra0 = {$urandom, $urandom};
            ra1 = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) ra0[31:24] = 8'hA2;
            if ($urandom_range(0, 1) == 1) ra1[31:24] = 8'hA2;
            run_txn(2'($urandom_range(1, 3)), ra0, ra1, int'($urandom_range(0, 3)), g_obs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sfi_req_arb
`default_nettype wire
